// File: rtl/if_id_queue_pkg.sv
// Shared Thumb front-end types and constants for the fetch/decode boundary.
package thumb_pkg;

  localparam int INST_W = 16;
  localparam int PC_W   = 32;

  localparam logic [INST_W-1:0] THUMB_NOP = 16'h0000;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } if_id_entry;

endpackage

// File: rtl/if_id_queue_if.sv
// Fetch-to-decode handshake bundle; the queue sits on the slave side.
interface if_id_queue_if
  import thumb_pkg::*;
#(
  parameter int AW = 1
);

  logic [PC_W-1:0]   IF_PC;
  logic [INST_W-1:0] FINST;
  logic              IF_VALID;
  logic              PC_REL_SEL;
  logic              ID_READY;
  logic [PC_W-1:0]   ID_PC;
  logic [INST_W-1:0] ID_INST;
  logic              ID_VALID;
  logic              IF_STALL;
  logic [AW:0]       Q_COUNT;

  modport slave (
    input  IF_PC, FINST, IF_VALID, PC_REL_SEL, ID_READY,
    output ID_PC, ID_INST, ID_VALID, IF_STALL, Q_COUNT
  );

  modport master (
    output IF_PC, FINST, IF_VALID, PC_REL_SEL, ID_READY,
    input  ID_PC, ID_INST, ID_VALID, IF_STALL, Q_COUNT
  );

endinterface

// File: rtl/if_id_queue_sync_fifo_ctrl.sv
// Generic FIFO bookkeeping: pointers, occupancy, full/empty and flush-to-zero.
module sync_fifo_ctrl #(
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_req,
  input  logic          pop_req,
  input  logic          flush,
  output logic [AW-1:0] wr_ptr,
  output logic [AW-1:0] rd_ptr,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic          push_en
);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic          pop_en;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);

  // Full blocks the push even when a pop frees a slot this cycle.
  assign push_en = push_req && !full  && !flush;
  assign pop_en  = pop_req  && !empty && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_en)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_en, pop_en})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_ptr = wr_ptr_q;
  assign rd_ptr = rd_ptr_q;
  assign count  = count_q;

endmodule

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue; a taken branch flushes all queued halfwords.
module if_id_queue
  import thumb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic          CLK,
  input  logic          nRESET,
  if_id_queue_if.slave  bus
);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          push_en;

  if_id_entry mem_q [DEPTH];
  if_id_entry mem_d [DEPTH];
  if_id_entry head;

  sync_fifo_ctrl #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ctrl (
    .clk      (CLK),
    .rst_n    (nRESET),
    .push_req (bus.IF_VALID),
    .pop_req  (bus.ID_READY),
    .flush    (bus.PC_REL_SEL),
    .wr_ptr   (wr_ptr),
    .rd_ptr   (rd_ptr),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .push_en  (push_en)
  );

  always_comb begin
    mem_d = mem_q;
    if (push_en) begin
      mem_d[wr_ptr] = '{pc: bus.IF_PC, inst: bus.FINST};
    end
  end

  // Storage carries no reset; validity comes solely from the registered count.
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

  assign head = mem_q[rd_ptr];

  assign bus.ID_VALID = !empty;
  assign bus.ID_PC    = empty ? '0 : head.pc;
  assign bus.ID_INST  = empty ? THUMB_NOP : head.inst;
  assign bus.IF_STALL = full;
  assign bus.Q_COUNT  = count;

endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboarded bench for if_id_queue: directed scenarios then random traffic.
module tb_if_id_queue;

  localparam int DEPTH = 2;
  localparam int AW    = 1;

  logic CLK = 1'b0;
  logic nRESET;

  int checks = 0;
  int errors = 0;

  // Expected queue contents as {pc, inst}; head at index 0.
  logic [47:0] exp_q [$];

  if_id_queue_if #(.AW(AW)) bus ();

  if_id_queue #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_dut (
    .CLK    (CLK),
    .nRESET (nRESET),
    .bus    (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_valid"}, 48'(bus.ID_VALID), 48'd0);
    chk({tag, "_pc"},    48'(bus.ID_PC),    48'd0);
    chk({tag, "_inst"},  48'(bus.ID_INST),  48'd0);
    chk({tag, "_stall"}, 48'(bus.IF_STALL), 48'd0);
    chk({tag, "_count"}, 48'(bus.Q_COUNT),  48'd0);
  endtask

  // Monitor: compare registered outputs with the model, then advance the model
  // using the inputs that the upcoming rising edge will see.
  always @(negedge CLK) begin
    if (!nRESET) begin
      exp_q.delete();
      chk_zero_outputs("rst_hold");
    end else begin
      int n;
      n = exp_q.size();
      chk("count", 48'(bus.Q_COUNT),  48'(n));
      chk("valid", 48'(bus.ID_VALID), 48'(n != 0));
      chk("stall", 48'(bus.IF_STALL), 48'(n == DEPTH));
      if (n != 0) begin
        chk("head_pc",   48'(bus.ID_PC),   48'(exp_q[0][47:16]));
        chk("head_inst", 48'(bus.ID_INST), 48'(exp_q[0][15:0]));
      end else begin
        chk("empty_pc",   48'(bus.ID_PC),   48'd0);
        chk("empty_inst", 48'(bus.ID_INST), 48'd0);
      end
      if (bus.PC_REL_SEL) begin
        exp_q.delete();
      end else begin
        if (bus.ID_READY && n > 0) void'(exp_q.pop_front());
        if (bus.IF_VALID && n < DEPTH) exp_q.push_back({bus.IF_PC, bus.FINST});
      end
    end
  end

  task automatic step(input logic v, input logic [31:0] pc, input logic [15:0] inst,
                      input logic rdy, input logic fl);
    bus.IF_VALID   = v;
    bus.IF_PC      = pc;
    bus.FINST      = inst;
    bus.ID_READY   = rdy;
    bus.PC_REL_SEL = fl;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [31:0] pc_r;
    bus.IF_VALID   = 1'b0;
    bus.IF_PC      = '0;
    bus.FINST      = '0;
    bus.ID_READY   = 1'b0;
    bus.PC_REL_SEL = 1'b0;
    nRESET = 1'b0;
    #1;
    chk_zero_outputs("por");
    repeat (2) step(0, 0, 0, 0, 0);
    nRESET = 1'b1;
    repeat (5) step(0, 0, 0, 0, 0);

    // Single flow-through
    step(1, 32'h100, 16'h2001, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);

    // Fill, stall, ignored push, drain in order
    step(1, 32'h100, 16'h2100, 0, 0);
    step(1, 32'h102, 16'h2102, 0, 0);
    step(1, 32'h104, 16'h2104, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);

    // Simultaneous push/pop at count=1 across pointer wrap
    step(1, 32'h200, 16'h3200, 0, 0);
    step(1, 32'h202, 16'h3202, 1, 0);
    step(1, 32'h204, 16'h3204, 1, 0);
    step(1, 32'h206, 16'h3206, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);

    // Flush when full, then branch target
    step(1, 32'h300, 16'h4300, 0, 0);
    step(1, 32'h302, 16'h4302, 0, 0);
    step(1, 32'h304, 16'h0000, 0, 1);
    step(1, 32'h400, 16'h5400, 0, 0);
    step(0, 0, 0, 1, 0);

    // Underflow guard
    repeat (3) step(0, 0, 0, 1, 0);
    step(1, 32'h500, 16'h6500, 1, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);

    // Asynchronous reset mid-operation while full
    step(1, 32'h600, 16'h7600, 0, 0);
    step(1, 32'h602, 16'h7602, 0, 0);
    step(0, 0, 0, 0, 0);
    #1;
    nRESET = 1'b0;
    #1;
    chk_zero_outputs("async_rst");
    step(1, 32'h700, 16'h7700, 1, 0);
    step(0, 0, 0, 0, 0);
    nRESET = 1'b1;
    step(1, 32'h800, 16'h7800, 0, 0);

    // Random traffic
    pc_r = 32'h1000;
    for (int i = 0; i < 3000; i++) begin
      logic fl;
      fl = ($urandom_range(0, 11) == 0);
      step(1'($urandom_range(0, 3) != 0), pc_r,
           fl ? 16'h0000 : 16'($urandom()),
           1'($urandom_range(0, 2) != 0), fl);
      pc_r = pc_r + 32'd2;
    end
    step(0, 0, 0, 0, 0);
    @(negedge CLK);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
